// File: rtl/if_stage_pipe_if.sv
// rtl/if_stage_pipe_if.sv - fetch-stage bus: hazard/branch inputs, imem port, IF/ID outputs, perf counters
// slave is the fetch stage; master is its environment (hazard unit, EXE, imem, ID).
interface if_stage_pipe_if #(
    parameter int unsigned CNT_W = 16
);
    logic              freeze;
    logic              branch_taken;
    logic [31:0]       branch_addr;
    logic              cnt_clr;
    logic [31:0]       imem_data;
    logic [31:0]       imem_addr;
    logic [31:0]       pc_out;
    logic [31:0]       instr_out;
    logic              valid_out;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport slave (
        input  freeze,
        input  branch_taken,
        input  branch_addr,
        input  cnt_clr,
        input  imem_data,
        output imem_addr,
        output pc_out,
        output instr_out,
        output valid_out,
        output stall_cnt,
        output flush_cnt
    );

    modport master (
        output freeze,
        output branch_taken,
        output branch_addr,
        output cnt_clr,
        output imem_data,
        input  imem_addr,
        input  pc_out,
        input  instr_out,
        input  valid_out,
        input  stall_cnt,
        input  flush_cnt
    );
endinterface

// File: rtl/if_stage_pipe.sv
// rtl/if_stage_pipe.sv - instruction fetch stage with IF/ID register and saturating stall/flush counters
// Priority everywhere: rst > branch_taken > freeze > advance; counters: rst > cnt_clr > increment.
module if_stage_pipe #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic           clk,
    input  logic           rst,
    if_stage_pipe_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic [31:0]      pc_out_q;
    logic [31:0]      instr_q;
    logic             valid_q;
    logic             run;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             stall_inc;
    logic             flush_inc;

    assign pc_plus4  = pc + 32'd4;
    assign stall_inc = run && bus.freeze && !bus.branch_taken;
    assign flush_inc = run && bus.branch_taken;

    // The first edge after reset only releases the stage; fetching starts on the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (run) begin
            if (bus.branch_taken) begin
                pc <= {bus.branch_addr[31:2], 2'b00};
            end else if (!bus.freeze) begin
                pc <= pc_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out_q <= 32'h0;
            instr_q  <= 32'h0;
            valid_q  <= 1'b0;
        end else if (run) begin
            if (bus.branch_taken) begin
                pc_out_q <= 32'h0;
                instr_q  <= 32'h0;
                valid_q  <= 1'b0;
            end else if (!bus.freeze) begin
                pc_out_q <= pc_plus4;
                instr_q  <= bus.imem_data;
                valid_q  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.cnt_clr) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc && (stall_q != CNT_MAX)) begin
                stall_q <= stall_q + CNT_ONE;
            end
            if (flush_inc && (flush_q != CNT_MAX)) begin
                flush_q <= flush_q + CNT_ONE;
            end
        end
    end

    assign bus.imem_addr = pc;
    assign bus.pc_out    = pc_out_q;
    assign bus.instr_out = instr_q;
    assign bus.valid_out = valid_q;
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
endmodule

// File: doc/if_stage_pipe.md
Name: if_stage_pipe

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 32-bit ARM 5-stage core.
- Holds the PC and drives the instruction-memory address.
- Consumes the hazard unit's stall output (freeze) and the EXE-stage branch outcome (branch_taken/branch_addr).
- Presents {PC+4, instruction, valid} to the ID stage.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of stall/flush performance counters

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
freeze  input  1  hazard stall from hazard unit; hold PC and IF/ID register
branch_taken  input  1  branch resolved taken in EXE; redirect PC, flush IF/ID
branch_addr  input  32  branch target address
cnt_clr  input  1  synchronous clear of performance counters
imem_data  input  32  instruction word from instruction memory, combinational read of imem_addr
imem_addr  output  32  current PC, to instruction memory
pc_out  output  32  registered PC+4 of fetched instruction, to ID stage
instr_out  output  32  registered instruction, to ID stage
valid_out  output  1  IF/ID register holds a real instruction
stall_cnt  output  CNT_W  cycles stalled by freeze
flush_cnt  output  CNT_W  IF/ID flushes caused by branch_taken

Behaviour:
Clocking and reset
- Single clock domain: clk.
- rst is synchronous and active-high. It wins over every other input.
- On a rst edge: pc <= RESET_PC, pc_out <= 0, instr_out <= 32'h0, valid_out <= 0, stall_cnt <= 0, flush_cnt <= 0.
- rst asserted mid-operation discards any in-flight fetch. There is no partial state.

PC register
- imem_addr = pc, combinational from the register.
- Update priority, highest first: rst > branch_taken > freeze > advance.
  - branch_taken: pc <= {branch_addr[31:2], 2'b00}. Misaligned targets are force-aligned.
  - freeze (branch_taken=0): pc holds.
  - otherwise: pc <= pc + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.

IF/ID register, same priority order
- branch_taken: flush. pc_out <= 0, instr_out <= 0, valid_out <= 0.
- freeze: pc_out, instr_out and valid_out all hold.
- otherwise: pc_out <= pc + 4, instr_out <= imem_data, valid_out <= 1.

Latency and ordering
- An instruction at address A reaches instr_out on the first edge after pc==A with freeze=0.
- The first valid_out=1 appears on the 2nd edge after rst deasserts: one edge releases reset, the next captures.
- branch_taken together with freeze: branch wins. A stall on a wrong-path instruction is irrelevant.
- The target instruction reaches instr_out one cycle after the redirect edge, unless frozen.

Performance counters
- Priority: rst > cnt_clr > increment.
- stall_cnt increments on each edge with freeze=1 and branch_taken=0.
- flush_cnt increments on each edge with branch_taken=1.
- Both saturate at 2^CNT_W-1 and do not wrap.
- cnt_clr asserted with an increment condition in the same cycle: result is 0.

Test Plan:
- Reset/startup: hold rst 2 cycles, release, imem_data = 32'hE3A0_1001 for addr 0 -> valid_out=0 at first edge after release; next edge instr_out=32'hE3A0_1001, pc_out=4; imem_addr steps 0,4,8.
- Freeze: with pc=8, assert freeze 3 cycles -> imem_addr stays 8, pc_out/instr_out/valid_out unchanged 3 cycles, stall_cnt=3; on release pc advances to 12.
- Branch beats freeze: pc=16, branch_taken=1, freeze=1, branch_addr=32'h0000_0103 -> next edge pc=32'h100, valid_out=0, instr_out=0, flush_cnt=1, stall_cnt unchanged; following edge pc_out=32'h104.
- Wrap: branch to 32'hFFFF_FFFC, then run free -> imem_addr 32'hFFFF_FFFC then 0; pc_out for that fetch = 0.
- Counter saturation/clear: CNT_W=4, freeze held 20 cycles -> stall_cnt sticks at 15; assert cnt_clr with freeze=1 -> stall_cnt=0 next edge.
- Reset mid-stall: freeze=1, pc=32'h40, assert rst one cycle -> pc=RESET_PC, valid_out=0, both counters 0 regardless of freeze.
